// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register bank.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  // True when addr names a real, writable register (in range and not a hardwired zero).
  function automatic logic legal_waddr(input int unsigned addr,
                                       input int unsigned num_regs,
                                       input logic        zero_reg);
    return (addr < num_regs) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  input  logic                clr_valid,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                set_en;
  logic [NUM_REGS-1:0] busy_nxt;

  assign set_en = issue_valid && legal_waddr(32'(issue_addr), NUM_REGS, ZERO_REG);

  // Clear is applied before set so a same-cycle issue to the written register keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_valid) busy_nxt[clr_addr[IDX_W-1:0]] = 1'b0;
    if (set_en)    busy_nxt[issue_addr[IDX_W-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-port register bank with pending-write scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; undefined gives read-before-write.
module reg_bank_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_RD*ADDR_W-1:0] RADDR,
  output logic [NUM_RD*DATA_W-1:0] RDATA,
  output logic [NUM_RD-1:0]        RBUSY,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WADDR,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic                     ISSUE_VALID,
  input  logic [ADDR_W-1:0]        ISSUE_ADDR
);

  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam bit          ZERO_BIT = (ZERO_REG != 0);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en;

  assign wr_en = WE && legal_waddr(32'(WADDR), NUM_REGS, ZERO_BIT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     mem <= '{default: '0};
    else if (wr_en) mem[WADDR[IDX_W-1:0]] <= WDATA;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_BIT)
  ) u_scoreboard (
    .clk         (CLK),
    .rst_n       (RST_N),
    .issue_valid (ISSUE_VALID),
    .issue_addr  (ISSUE_ADDR),
    .clr_valid   (wr_en),
    .clr_addr    (WADDR),
    .busy        (busy)
  );

`ifdef REGFILE_BYPASS_EN
  // Bypass is held off during reset so outputs stay zero while RST_N is low.
  logic byp_en;
  assign byp_en = wr_en && RST_N;
`endif

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_ok;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra    = RADDR[p*ADDR_W +: ADDR_W];
    assign ra_ok = legal_waddr(32'(ra), NUM_REGS, ZERO_BIT);

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (ra_ok) begin
        rd = mem[ra[IDX_W-1:0]];
        rb = busy[ra[IDX_W-1:0]];
      end
`ifdef REGFILE_BYPASS_EN
      if (byp_en && (ra == WADDR)) begin
        rd = WDATA;
        rb = 1'b0;
      end
`endif
    end

    assign RDATA[p*DATA_W +: DATA_W] = rd;
    assign RBUSY[p]                  = rb;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Self-checking bench for reg_bank_mp (16 registers, 4 read ports, zero register on).
module tb_reg_bank_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 16;
  localparam int unsigned NP = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [NP*AW-1:0] RADDR;
  logic [NP*DW-1:0] RDATA;
  logic [NP-1:0]    RBUSY;
  logic             WE;
  logic [AW-1:0]    WADDR;
  logic [DW-1:0]    WDATA;
  logic             ISSUE_VALID;
  logic [AW-1:0]    ISSUE_ADDR;

  reg_bank_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_REGS (NR),
    .NUM_RD   (NP),
    .ZERO_REG (1)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RADDR       (RADDR),
    .RDATA       (RDATA),
    .RBUSY       (RBUSY),
    .WE          (WE),
    .WADDR       (WADDR),
    .WDATA       (WDATA),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_ADDR  (ISSUE_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    int unsigned port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int unsigned port,
                           input logic [31:0] data, input logic busy);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.data = data;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic expect_all(input string tag, input logic [31:0] data, input logic busy);
    for (int unsigned p = 0; p < NP; p++) expect_rd(tag, p, data, busy);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_p%0d_data", e.tag, e.port), RDATA[e.port*DW +: DW], e.data);
      chk($sformatf("%s_p%0d_busy", e.tag, e.port), 32'(RBUSY[e.port]), 32'(e.busy));
    end
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    RADDR = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] wvals [5];
  int          wregs [5];

  initial begin
    RST_N = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
    ISSUE_VALID = 1'b0; ISSUE_ADDR = '0; RADDR = '0;
    #2;
    for (int a = 0; a < 32; a++) begin
      set_rd(a, a, a, a);
      expect_all("rst_sweep", 32'h0, 1'b0);
      drain();
    end
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();

    // basic write / read, zero register
    WE = 1'b1; WADDR = 5'd5; WDATA = 32'hDEADBEEF; set_rd(1, 1, 1, 1);
    cyc();
    WE = 1'b0; set_rd(5, 5, 5, 5);
    expect_all("r5", 32'hDEADBEEF, 1'b0);
    drain();
    WE = 1'b1; WADDR = 5'd0; WDATA = 32'h1234; set_rd(0, 0, 0, 0);
    expect_all("r0_wcyc", 32'h0, 1'b0);
    drain();
    cyc();
    WE = 1'b0;
    expect_all("r0", 32'h0, 1'b0);
    drain();

    // same-cycle write/read of r7
    set_rd(7, 5, 0, 0);
    WE = 1'b1; WADDR = 5'd7; WDATA = 32'hA5A5A5A5;
    expect_rd("r7_wcyc", 0, BYP ? 32'hA5A5A5A5 : 32'h0, 1'b0);
    expect_rd("r5_keep", 1, 32'hDEADBEEF, 1'b0);
    drain();
    cyc();
    WE = 1'b0;
    expect_rd("r7", 0, 32'hA5A5A5A5, 1'b0);
    drain();

    // issue r3, busy persists, writeback clears
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd3; set_rd(3, 3, 3, 3);
    expect_all("r3_icyc", 32'h0, 1'b0);
    drain();
    cyc();
    ISSUE_VALID = 1'b0;
    expect_all("r3_busy1", 32'h0, 1'b1);
    drain();
    cyc(); cyc(); cyc();
    expect_all("r3_busy3", 32'h0, 1'b1);
    drain();
    WE = 1'b1; WADDR = 5'd3; WDATA = 32'h33;
    expect_all("r3_wcyc", BYP ? 32'h33 : 32'h0, BYP ? 1'b0 : 1'b1);
    drain();
    cyc();
    WE = 1'b0;
    expect_all("r3_clr", 32'h33, 1'b0);
    drain();

    // issue and write same register: set wins
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd9; WE = 1'b1; WADDR = 5'd9; WDATA = 32'h99;
    set_rd(9, 9, 9, 9);
    expect_all("r9_cyc", BYP ? 32'h99 : 32'h0, 1'b0);
    drain();
    cyc();
    ISSUE_VALID = 1'b0; WE = 1'b0;
    expect_all("r9", 32'h99, 1'b1);
    drain();
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd0;
    cyc();
    ISSUE_VALID = 1'b0;
    set_rd(0, 9, 0, 9);
    expect_rd("iss_r0", 0, 32'h0, 1'b0);
    expect_rd("r9_hold", 1, 32'h99, 1'b1);
    expect_rd("iss_r0", 2, 32'h0, 1'b0);
    expect_rd("r9_hold", 3, 32'h99, 1'b1);
    drain();

    // out-of-range write and issue must not alias onto r4
    WE = 1'b1; WADDR = 5'd20; WDATA = 32'hBAD0BAD0;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 5'd20; set_rd(20, 4, 20, 4);
    expect_all("r20_cyc", 32'h0, 1'b0);
    drain();
    cyc();
    WE = 1'b0; ISSUE_VALID = 1'b0;
    expect_all("r20", 32'h0, 1'b0);
    drain();

    // distinct registers on every port, including the top boundary
    wregs = '{1, 2, 4, 6, 15};
    wvals = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h66666666, 32'hF0F0000F};
    for (int i = 0; i < 5; i++) begin
      WE = 1'b1; WADDR = 5'(wregs[i]); WDATA = wvals[i];
      cyc();
    end
    WE = 1'b0;
    set_rd(1, 2, 4, 6);
    for (int unsigned p = 0; p < NP; p++) expect_rd("distinct", p, wvals[p], 1'b0);
    drain();
    set_rd(15, 16, 31, 6);
    expect_rd("r15", 0, 32'hF0F0000F, 1'b0);
    expect_rd("r16", 1, 32'h0, 1'b0);
    expect_rd("r31", 2, 32'h0, 1'b0);
    expect_rd("r6", 3, 32'h66666666, 1'b0);
    drain();

    // asynchronous reset mid-run
    set_rd(5, 7, 9, 15);
    RST_N = 1'b0;
    expect_all("rst_mid", 32'h0, 1'b0);
    drain();
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    expect_all("post_rst", 32'h0, 1'b0);
    drain();
    set_rd(1, 2, 4, 6);
    expect_all("post_rst2", 32'h0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
